piece_queue: RTL and testbench
==============================

// Module: piece_queue
// PURPOSE
// - Consumes the free-running 3-bit piece code from the piece generator and keeps a preview queue of upcoming pieces.
// - Serves spawn requests from the game-control FSM: pops the queue head as the active piece, then refills the queue.
// - Sits between the piece generator (upstream) and the board/game FSM (downstream).
// PARAMETERS
// - DEPTH  3  preview entries held (legal 1..4); entry 0 = next piece to spawn
// PORTS
// - clk          in   1        system clock, single clock domain
// - rst          in   1        reset: synchronous, active-high
// - rand_piece   in   3        generator code, new value each cycle; 0..6 valid, 7 invalid
// - spawn_req    in   1        1-cycle pulse from game FSM: request next active piece
// - queue_ready  out  1        queue full and idle; spawn_req/hold_req accepted only when 1
// - spawn_valid  out  1        1-cycle pulse: spawn_piece is the new active piece
// - spawn_piece  out  3        new active piece code; holds last value between pulses
// - preview      out  3*DEPTH  queue contents, entry i at [3i+2:3i]; unfilled entries = 3'd7
// - hold_req     in   1        [HOLD_EN only] swap active piece with hold slot
// - hold_piece   out  3        [HOLD_EN only] hold slot contents; 3'd7 = empty
// BEHAVIOUR
// - Reset: queue entries = 7, queue_ready=0, spawn_valid=0, spawn_piece=7, hold_piece=7, hold lock clear, state FILL.
// - FSM states FILL, READY, SPAWN.
// - FILL: each cycle sample rand_piece.
//   - Reject if value is 7.
//   - Reject if value equals the last accepted piece, unless the previous sample was also rejected for repeat (one reroll max).
//   - Accepted values are written at the lowest unfilled entry.
//   - -> READY in the cycle the queue becomes full.
// - READY: queue_ready=1.
//   - spawn_req -> SPAWN.
//   - spawn_req and hold_req asserted together: spawn wins, hold_req dropped.
//   - Requests in FILL or SPAWN are dropped, not queued.
// - SPAWN (one cycle):
//   - spawn_valid=1, spawn_piece=entry 0 (latency 1 cycle from accepted spawn_req).
//   - Entries shift down by one; top entry becomes 7.
//   - Active-piece register <= entry 0; hold lock clears.
//   - -> FILL.
// - Queue never overflows: writes occur only in FILL, and only to unfilled entries.
// - Empty queue never spawns: SPAWN is only reachable from READY.
// - rst mid-FILL or mid-SPAWN: full return to reset values next edge; no partial shift retained.
// - Repeat filter compares against the most recent accepted piece, including across spawns.
// CONFIGURATION
// - Macro PIECE_QUEUE_HOLD_EN.
// - Defined: hold_req/hold_piece ports exist. hold_req is accepted in READY when hold lock is clear and active piece != 7.
//   - Hold slot empty: hold <= active; behave exactly as spawn_req (SPAWN from queue head).
//   - Hold slot occupied: 1-cycle swap. spawn_valid=1, spawn_piece=hold, hold <= active, active <= old hold. Queue untouched; stays READY.
//   - Either case sets hold lock; lock clears on the next queue spawn.
//   - hold_req while locked: ignored.
// - Undefined: no hold ports, no hold logic; spawn-only behaviour.
// STRUCTURE
// - tetris_pkg:
//   - piece_t enum 3-bit (I=0,O,T,S,Z,J,L=6)
//   - PIECE_NONE=3'd7, NUM_PIECES=7
//   - queue FSM state enum
// - Sub-module piece_fifo: DEPTH-entry shift register.
//   - Inputs: write-at-lowest-empty, shift-down.
//   - Outputs: full flag, flattened entries.
// - Top: FSM, repeat filter, active/hold registers.
// TESTING
// - Reset, rand_piece cycles 0..6: queue_ready high 3 cycles after rst drops; preview = {2,1,0}.
// - rand_piece held at 4 constantly: first 4 accepted; second sample rejected; third accepted (reroll limit). Queue = {4,4,4} after 5 cycles.
// - rand_piece=7 for 10 cycles, then 1,2,3: no writes during the 7s; queue_ready only after 1,2,3 are accepted.
// - spawn_req in READY with preview {5,3,6}: next cycle spawn_valid=1, spawn_piece=6; preview {7,5,3}; queue_ready=0 until refilled.
// - spawn_req pulsed during FILL: no spawn_valid; state unchanged.
// - HOLD_EN, active=2, hold empty, queue head 6: hold_req gives spawn_piece=6, hold_piece=2. Second hold_req before next spawn is ignored. After next spawn, hold_req swaps the active piece with 2.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared piece codes and queue FSM state encoding for the piece queue.
// Optional hold-slot logic is enabled with the PIECE_QUEUE_HOLD_EN macro.
package tetris_pkg;

  typedef enum logic [2:0] {
    PieceI = 3'd0,
    PieceO = 3'd1,
    PieceT = 3'd2,
    PieceS = 3'd3,
    PieceZ = 3'd4,
    PieceJ = 3'd5,
    PieceL = 3'd6
  } piece_t;

  localparam logic [2:0]  PIECE_NONE = 3'd7;
  localparam int unsigned NUM_PIECES = 7;

  typedef enum logic [1:0] {
    StFill  = 2'd0,
    StReady = 2'd1,
    StSpawn = 2'd2
  } queue_state_e;

  // True for any real piece code (0..6), false for the empty/invalid marker.
  function automatic logic is_piece(logic [2:0] code);
    return code != PIECE_NONE;
  endfunction

endpackage

// File: rtl/piece_queue_if.sv
// Handshake bundle between generator, game FSM and the piece queue.
// hold_req/hold_piece exist only when PIECE_QUEUE_HOLD_EN is defined.
interface piece_queue_if #(
  parameter int unsigned DEPTH = 3
);

  logic [2:0]         rand_piece;
  logic               spawn_req;
  logic               queue_ready;
  logic               spawn_valid;
  logic [2:0]         spawn_piece;
  logic [3*DEPTH-1:0] preview;
`ifdef PIECE_QUEUE_HOLD_EN
  logic               hold_req;
  logic [2:0]         hold_piece;

  modport master (
    output rand_piece, spawn_req, hold_req,
    input  queue_ready, spawn_valid, spawn_piece, preview, hold_piece
  );

  modport slave (
    input  rand_piece, spawn_req, hold_req,
    output queue_ready, spawn_valid, spawn_piece, preview, hold_piece
  );
`else
  modport master (
    output rand_piece, spawn_req,
    input  queue_ready, spawn_valid, spawn_piece, preview
  );

  modport slave (
    input  rand_piece, spawn_req,
    output queue_ready, spawn_valid, spawn_piece, preview
  );
`endif

endinterface

// File: rtl/piece_fifo.sv
// DEPTH-entry preview shift register. Entries fill from index 0 upward and
// are always contiguous, so the fill level is just the count of real pieces.
module piece_fifo
  import tetris_pkg::*;
#(
  parameter int unsigned DEPTH = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en_i,
  input  logic [2:0]         wr_piece_i,
  input  logic               shift_i,
  output logic               full_o,
  output logic               last_slot_o,
  output logic [3*DEPTH-1:0] entries_o
);

  localparam int unsigned Top = DEPTH - 1;

  logic [2:0]  entries_q [DEPTH];
  logic [2:0]  entries_d [DEPTH];
  logic        wr_found;
  int unsigned filled_cnt;

  // Shift toward entry 0, or write into the lowest empty slot.
  always_comb begin
    entries_d = entries_q;
    wr_found  = 1'b0;
    if (shift_i) begin
      for (int i = 0; i < int'(Top); i++) begin
        entries_d[i] = entries_q[i+1];
      end
      entries_d[Top] = PIECE_NONE;
    end else if (wr_en_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (!wr_found && !is_piece(entries_q[i])) begin
          entries_d[i] = wr_piece_i;
          wr_found     = 1'b1;
        end
      end
    end
  end

  // Fill level, status flags and flattened view.
  always_comb begin
    filled_cnt = 0;
    entries_o  = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      filled_cnt       = filled_cnt + {31'd0, is_piece(entries_q[i])};
      entries_o[3*i+:3] = entries_q[i];
    end
    full_o      = (filled_cnt == DEPTH);
    last_slot_o = (filled_cnt == Top);
  end

  // Entry storage with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        entries_q[i] <= PIECE_NONE;
      end
    end else begin
      entries_q <= entries_d;
    end
  end

endmodule

// File: rtl/piece_queue.sv
// Piece preview queue: filters generator codes into a preview FIFO and serves
// spawn requests. Define PIECE_QUEUE_HOLD_EN to add the hold slot.
// Spawn/hold side effects (shift, active/hold update) all land on the edge
// that accepts the request, so the SPAWN cycle already shows the shifted queue.
module piece_queue
  import tetris_pkg::*;
#(
  parameter int unsigned DEPTH = 3
) (
  input  logic         clk,
  input  logic         rst,
  piece_queue_if.slave bus
);

  queue_state_e state_q, state_d;
  logic         spawn_valid_q, spawn_valid_d;
  logic [2:0]   spawn_piece_q, spawn_piece_d;
  logic [2:0]   last_q, last_d;
  logic         reroll_q, reroll_d;
`ifdef PIECE_QUEUE_HOLD_EN
  logic [2:0]   active_q, active_d;
  logic [2:0]   hold_q, hold_d;
  logic         lock_q, lock_d;
`endif

  logic               fifo_wr;
  logic               fifo_shift;
  logic               fifo_full;
  logic               fifo_last_slot;
  logic [3*DEPTH-1:0] fifo_entries;
  logic [2:0]         head;

  piece_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (fifo_wr),
    .wr_piece_i (bus.rand_piece),
    .shift_i    (fifo_shift),
    .full_o     (fifo_full),
    .last_slot_o(fifo_last_slot),
    .entries_o  (fifo_entries)
  );

  assign head            = fifo_entries[2:0];
  assign bus.queue_ready = (state_q == StReady);
  assign bus.spawn_valid = spawn_valid_q;
  assign bus.spawn_piece = spawn_piece_q;
  assign bus.preview     = fifo_entries;
`ifdef PIECE_QUEUE_HOLD_EN
  assign bus.hold_piece  = hold_q;
`endif

  // Next-state: fill filter, request arbitration, spawn/hold updates.
  always_comb begin
    state_d       = state_q;
    spawn_valid_d = 1'b0;
    spawn_piece_d = spawn_piece_q;
    last_d        = last_q;
    reroll_d      = reroll_q;
    fifo_wr       = 1'b0;
    fifo_shift    = 1'b0;
`ifdef PIECE_QUEUE_HOLD_EN
    active_d      = active_q;
    hold_d        = hold_q;
    lock_d        = lock_q;
`endif
    unique case (state_q)
      StFill: begin
        if (fifo_full) begin
          state_d = StReady;
        end else if (!is_piece(bus.rand_piece)) begin
          reroll_d = 1'b0;
        end else if (bus.rand_piece == last_q && !reroll_q) begin
          // First repeat is rerolled; a second consecutive repeat is kept.
          reroll_d = 1'b1;
        end else begin
          fifo_wr  = 1'b1;
          last_d   = bus.rand_piece;
          reroll_d = 1'b0;
          if (fifo_last_slot) state_d = StReady;
        end
      end
      StReady: begin
        if (bus.spawn_req) begin
          fifo_shift    = 1'b1;
          spawn_valid_d = 1'b1;
          spawn_piece_d = head;
          state_d       = StSpawn;
`ifdef PIECE_QUEUE_HOLD_EN
          active_d      = head;
          lock_d        = 1'b0;
        end else if (bus.hold_req && !lock_q && is_piece(active_q)) begin
          lock_d        = 1'b1;
          hold_d        = active_q;
          spawn_valid_d = 1'b1;
          if (!is_piece(hold_q)) begin
            // Empty slot: park the active piece and spawn from the queue.
            fifo_shift    = 1'b1;
            spawn_piece_d = head;
            active_d      = head;
            state_d       = StSpawn;
          end else begin
            spawn_piece_d = hold_q;
            active_d      = hold_q;
          end
`endif
        end
      end
      StSpawn: state_d = StFill;
      default: state_d = StFill;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StFill;
      spawn_valid_q <= 1'b0;
      spawn_piece_q <= PIECE_NONE;
      last_q        <= PIECE_NONE;
      reroll_q      <= 1'b0;
`ifdef PIECE_QUEUE_HOLD_EN
      active_q      <= PIECE_NONE;
      hold_q        <= PIECE_NONE;
      lock_q        <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      spawn_valid_q <= spawn_valid_d;
      spawn_piece_q <= spawn_piece_d;
      last_q        <= last_d;
      reroll_q      <= reroll_d;
`ifdef PIECE_QUEUE_HOLD_EN
      active_q      <= active_d;
      hold_q        <= hold_d;
      lock_q        <= lock_d;
`endif
    end
  end

endmodule

// File: tb/tb_piece_queue.sv
// Self-checking bench for piece_queue: directed scenarios plus a randomized
// run against a queue-based reference model. Hold scenarios are built only
// when PIECE_QUEUE_HOLD_EN is defined.
module tb_piece_queue;

  localparam int unsigned DEPTH = 3;
  localparam int MFill = 0, MReady = 1, MSpawn = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  piece_queue_if #(.DEPTH(DEPTH)) bus ();

  piece_queue #(
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int mq[$];
  int m_last;
  bit m_reroll;
  int m_mode;
  bit m_valid;
  int m_piece;
  int m_active;
  int m_hold;
  bit m_lock;

  function automatic logic [3*DEPTH-1:0] exp_preview();
    logic [3*DEPTH-1:0] p;
    for (int i = 0; i < int'(DEPTH); i++) begin
      p[3*i+:3] = (i < mq.size()) ? 3'(mq[i]) : 3'd7;
    end
    return p;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_last = 7; m_reroll = 0; m_mode = MFill; m_valid = 0;
    m_piece = 7; m_active = 7; m_hold = 7; m_lock = 0;
  endtask

  task automatic model_pop();
    m_piece  = mq.pop_front();
    m_valid  = 1;
    m_active = m_piece;
    m_lock   = 0;
    m_mode   = MSpawn;
  endtask

  task automatic model_step(input int r, input bit s, input bit h, input bit rs);
    int t;
    if (rs) begin
      model_reset();
      return;
    end
    m_valid = 0;
    if (m_mode == MFill) begin
      if (r == 7) m_reroll = 0;
      else if (r == m_last && !m_reroll) m_reroll = 1;
      else begin
        mq.push_back(r);
        m_last = r;
        m_reroll = 0;
        if (mq.size() == int'(DEPTH)) m_mode = MReady;
      end
    end else if (m_mode == MReady) begin
      if (s) model_pop();
`ifdef PIECE_QUEUE_HOLD_EN
      else if (h && !m_lock && m_active != 7) begin
        if (m_hold == 7) begin
          m_hold = m_active;
          model_pop();
          m_lock = 1;
        end else begin
          t = m_hold;
          m_valid = 1; m_piece = t;
          m_hold = m_active; m_active = t; m_lock = 1;
        end
      end
`endif
    end else begin
      m_mode = MFill;
    end
  endtask

  task automatic tick(input int r, input bit s, input bit h);
    bus.rand_piece = 3'(r);
    bus.spawn_req  = s;
`ifdef PIECE_QUEUE_HOLD_EN
    bus.hold_req   = h;
`endif
    @(posedge clk);
    model_step(r, s, h, rst);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(0, 0, 0);
    tick(0, 0, 0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3, 1, 1);
    tick(5, 1, 1);
    checks++;
    if (bus.queue_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %0b want 0", bus.queue_ready);
    end
    checks++;
    if (bus.spawn_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %0b want 0", bus.spawn_valid);
    end
    checks++;
    if (bus.spawn_piece !== 3'd7) begin
      errors++; $display("FAIL reset_piece: got %0d want 7", bus.spawn_piece);
    end
    checks++;
    if (bus.preview !== 9'h1FF) begin
      errors++; $display("FAIL reset_preview: got %h want 1ff", bus.preview);
    end
`ifdef PIECE_QUEUE_HOLD_EN
    checks++;
    if (bus.hold_piece !== 3'd7) begin
      errors++; $display("FAIL reset_hold: got %0d want 7", bus.hold_piece);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_fill_order();
    do_reset();
    tick(0, 0, 0);
    tick(1, 0, 0);
    checks++;
    if (bus.queue_ready !== 1'b0) begin
      errors++; $display("FAIL fill_early_ready: got %0b want 0", bus.queue_ready);
    end
    tick(2, 0, 0);
    checks++;
    if (bus.queue_ready !== 1'b1) begin
      errors++; $display("FAIL fill_ready: got %0b want 1", bus.queue_ready);
    end
    checks++;
    if (bus.preview !== {3'd2, 3'd1, 3'd0}) begin
      errors++; $display("FAIL fill_preview: got %h want %h", bus.preview, {3'd2, 3'd1, 3'd0});
    end
  endtask

  task automatic test_repeat();
    do_reset();
    for (int i = 0; i < 4; i++) tick(4, 0, 0);
    checks++;
    if (bus.preview !== {3'd7, 3'd4, 3'd4} || bus.queue_ready !== 1'b0) begin
      errors++; $display("FAIL repeat_partial: got %h/%0b want %h/0", bus.preview,
                         bus.queue_ready, {3'd7, 3'd4, 3'd4});
    end
    tick(4, 0, 0);
    checks++;
    if (bus.preview !== {3'd4, 3'd4, 3'd4} || bus.queue_ready !== 1'b1) begin
      errors++; $display("FAIL repeat_full: got %h/%0b want %h/1", bus.preview,
                         bus.queue_ready, {3'd4, 3'd4, 3'd4});
    end
  endtask

  task automatic test_invalid();
    do_reset();
    for (int i = 0; i < 10; i++) tick(7, 0, 0);
    checks++;
    if (bus.preview !== 9'h1FF || bus.queue_ready !== 1'b0) begin
      errors++; $display("FAIL invalid_nowrite: got %h/%0b want 1ff/0", bus.preview,
                         bus.queue_ready);
    end
    tick(1, 0, 0);
    tick(2, 0, 0);
    checks++;
    if (bus.queue_ready !== 1'b0) begin
      errors++; $display("FAIL invalid_early_ready: got %0b want 0", bus.queue_ready);
    end
    tick(3, 0, 0);
    checks++;
    if (bus.preview !== {3'd3, 3'd2, 3'd1} || bus.queue_ready !== 1'b1) begin
      errors++; $display("FAIL invalid_fill: got %h/%0b want %h/1", bus.preview,
                         bus.queue_ready, {3'd3, 3'd2, 3'd1});
    end
  endtask

  task automatic test_spawn();
    do_reset();
    tick(6, 0, 0);
    tick(3, 0, 0);
    tick(5, 0, 0);
    tick(0, 1, 0);
    checks++;
    if (bus.spawn_valid !== 1'b1 || bus.spawn_piece !== 3'd6) begin
      errors++; $display("FAIL spawn_pulse: got %0b/%0d want 1/6", bus.spawn_valid,
                         bus.spawn_piece);
    end
    checks++;
    if (bus.preview !== {3'd7, 3'd5, 3'd3} || bus.queue_ready !== 1'b0) begin
      errors++; $display("FAIL spawn_shift: got %h/%0b want %h/0", bus.preview,
                         bus.queue_ready, {3'd7, 3'd5, 3'd3});
    end
    tick(1, 0, 0);
    checks++;
    if (bus.spawn_valid !== 1'b0 || bus.spawn_piece !== 3'd6 || bus.preview !== {3'd7, 3'd5, 3'd3}) begin
      errors++; $display("FAIL spawn_after: got %0b/%0d/%h want 0/6/%h", bus.spawn_valid,
                         bus.spawn_piece, bus.preview, {3'd7, 3'd5, 3'd3});
    end
    tick(1, 0, 0);
    checks++;
    if (bus.preview !== {3'd1, 3'd5, 3'd3} || bus.queue_ready !== 1'b1) begin
      errors++; $display("FAIL spawn_refill: got %h/%0b want %h/1", bus.preview,
                         bus.queue_ready, {3'd1, 3'd5, 3'd3});
    end
  endtask

  task automatic test_spawn_in_fill();
    do_reset();
    tick(0, 1, 0);
    tick(1, 1, 0);
    checks++;
    if (bus.spawn_valid !== 1'b0 || bus.preview !== {3'd7, 3'd1, 3'd0}) begin
      errors++; $display("FAIL fill_spawn_drop: got %0b/%h want 0/%h", bus.spawn_valid,
                         bus.preview, {3'd7, 3'd1, 3'd0});
    end
    tick(2, 0, 0);
    checks++;
    if (bus.queue_ready !== 1'b1 || bus.spawn_valid !== 1'b0) begin
      errors++; $display("FAIL fill_spawn_state: got %0b/%0b want 1/0", bus.queue_ready,
                         bus.spawn_valid);
    end
  endtask

`ifdef PIECE_QUEUE_HOLD_EN
  task automatic test_hold();
    do_reset();
    tick(2, 0, 0); tick(6, 0, 0); tick(1, 0, 0);
    tick(0, 1, 0);
    tick(0, 0, 0);
    tick(3, 0, 0);
    tick(0, 0, 1);
    checks++;
    if (bus.spawn_valid !== 1'b1 || bus.spawn_piece !== 3'd6 || bus.hold_piece !== 3'd2) begin
      errors++; $display("FAIL hold_first: got %0b/%0d/%0d want 1/6/2", bus.spawn_valid,
                         bus.spawn_piece, bus.hold_piece);
    end
    tick(0, 0, 0);
    tick(4, 0, 1);
    tick(0, 0, 1);
    checks++;
    if (bus.spawn_valid !== 1'b0 || bus.hold_piece !== 3'd2 || bus.queue_ready !== 1'b1) begin
      errors++; $display("FAIL hold_locked: got %0b/%0d/%0b want 0/2/1", bus.spawn_valid,
                         bus.hold_piece, bus.queue_ready);
    end
    tick(0, 1, 0);
    tick(0, 0, 0);
    tick(5, 0, 0);
    tick(0, 0, 1);
    checks++;
    if (bus.spawn_valid !== 1'b1 || bus.spawn_piece !== 3'd2 || bus.hold_piece !== 3'd1) begin
      errors++; $display("FAIL hold_swap: got %0b/%0d/%0d want 1/2/1", bus.spawn_valid,
                         bus.spawn_piece, bus.hold_piece);
    end
    checks++;
    if (bus.queue_ready !== 1'b1 || bus.preview !== {3'd5, 3'd4, 3'd3}) begin
      errors++; $display("FAIL hold_swap_queue: got %0b/%h want 1/%h", bus.queue_ready,
                         bus.preview, {3'd5, 3'd4, 3'd3});
    end
  endtask
`endif

  task automatic test_random();
    int r;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      r = ($urandom_range(0, 3) == 0) ? m_last : int'($urandom_range(0, 7));
      tick(r, $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0);
      rst = 1'b0;
      checks++;
      if (bus.queue_ready !== (m_mode == MReady) || bus.spawn_valid !== m_valid ||
          bus.spawn_piece !== 3'(m_piece) || bus.preview !== exp_preview()) begin
        errors++;
        $display("FAIL random_cycle%0d: got rdy=%0b v=%0b p=%0d q=%h want %0b/%0b/%0d/%h",
                 c, bus.queue_ready, bus.spawn_valid, bus.spawn_piece, bus.preview,
                 m_mode == MReady, m_valid, m_piece, exp_preview());
      end
`ifdef PIECE_QUEUE_HOLD_EN
      checks++;
      if (bus.hold_piece !== 3'(m_hold)) begin
        errors++; $display("FAIL random_hold%0d: got %0d want %0d", c, bus.hold_piece, m_hold);
      end
`endif
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.rand_piece = 3'd0;
    bus.spawn_req  = 1'b0;
`ifdef PIECE_QUEUE_HOLD_EN
    bus.hold_req   = 1'b0;
`endif
    model_reset();
    test_reset();
    test_fill_order();
    test_repeat();
    test_invalid();
    test_spawn();
    test_spawn_in_fill();
`ifdef PIECE_QUEUE_HOLD_EN
    test_hold();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
